// File: rtl/hs_req_tx.sv
// Source side of a 4-phase req/ack handshake that carries one word per transfer into another clock domain.
// Optional macro HS_REQ_TX_BUF_EN adds a one-entry pending buffer in front of the launch path.
module hs_req_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_ff,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              tx_ack,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK_LOW
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   tx_ack_s;
    logic                   tx_req_q, tx_req_d;
    logic [DATA_W-1:0]      tx_data_q, tx_data_d;
    logic                   done_q, done_d;
    logic                   accept;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_ff) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], tx_ack};
        end
    end

    assign tx_ack_s = ack_sync_q[SYNC_STAGES-1];
    assign accept   = in_valid && in_ready;

`ifdef HS_REQ_TX_BUF_EN
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;

    assign in_ready = !rst && !buf_full_q;
`else
    // A stale acknowledge from an aborted transfer must drain before a new request may rise.
    assign in_ready = !rst && (state_q == IDLE) && !tx_ack_s;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
`ifdef HS_REQ_TX_BUF_EN
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef HS_REQ_TX_BUF_EN
                if (!tx_ack_s && buf_full_q) begin
                    tx_data_d  = buf_data_q;
                    tx_req_d   = 1'b1;
                    buf_full_d = 1'b0;
                    state_d    = REQ;
                end else if (!tx_ack_s && accept) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
                end
`else
                if (accept) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
                end
`endif
            end
            REQ: begin
                if (tx_ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (!tx_ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef HS_REQ_TX_BUF_EN
        // Words arriving while the launch path is occupied wait in the buffer.
        if (accept && ((state_q != IDLE) || tx_ack_s)) begin
            buf_data_d = in_data;
            buf_full_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_ff) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

`ifdef HS_REQ_TX_BUF_EN
    always_ff @(posedge clk_ff) begin
        if (rst) begin
            buf_full_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
        end
    end

    // NOTE: buffer storage is left unreset; buf_full_q alone says whether it holds a word.
    always_ff @(posedge clk_ff) begin
        buf_data_q <= buf_data_d;
    end
`endif

    assign tx_req  = tx_req_q;
    assign tx_data = tx_data_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_hs_req_tx.sv
// Directed bench for hs_req_tx: a vector table for the basic handshake plus sequences for
// back-pressure, reset with a stale acknowledge and (with HS_REQ_TX_BUF_EN) the pending buffer.
module tb_hs_req_tx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk_ff = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_req;
    logic              tx_ack;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    // Reference copy of the acknowledge synchronizer, used to predict in_ready after reset.
    logic [SYNC_STAGES-1:0] ack_m = '0;

    hs_req_tx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_ff   (clk_ff),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .tx_ack   (tx_ack),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_ff = ~clk_ff;

    always @(posedge clk_ff) begin
        if (rst) ack_m <= '0;
        else     ack_m <= {ack_m[SYNC_STAGES-2:0], tx_ack};
    end

    typedef struct {
        logic              rst;
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              ack;
        logic              e_rdy;
        logic              e_req;
        logic [DATA_W-1:0] e_data;
        logic              e_busy;
        logic              e_done;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [DATA_W-1:0] d,
                                input logic a, input logic rdy, input logic rq,
                                input logic [DATA_W-1:0] ed, input logic bz, input logic dn);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.ack = a;
        t.e_rdy = rdy; t.e_req = rq; t.e_data = ed; t.e_busy = bz; t.e_done = dn;
        return t;
    endfunction

    // Responder: raises ack 3 cycles after req rises, drops it 3 cycles after req falls.
    int resp_cnt = 0;
    task automatic respond();
        if (tx_req && !tx_ack) begin
            resp_cnt++;
            if (resp_cnt == 3) begin tx_ack = 1'b1; resp_cnt = 0; end
        end else if (!tx_req && tx_ack) begin
            resp_cnt++;
            if (resp_cnt == 3) begin tx_ack = 1'b0; resp_cnt = 0; end
        end else begin
            resp_cnt = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tx_ack   = 1'b0;

`ifndef HS_REQ_TX_BUF_EN
        begin : table_tests
            vec_t vecs[21];
            //            rst v  data   ack | rdy req  data   bsy dn
            vecs[0]  = mk(1, 0, 8'h00, 0,   0,  0, 8'h00, 0,  0);
            vecs[1]  = mk(1, 0, 8'h00, 0,   0,  0, 8'h00, 0,  0);
            vecs[2]  = mk(0, 0, 8'h00, 0,   1,  0, 8'h00, 0,  0);
            vecs[3]  = mk(0, 1, 8'hA5, 0,   0,  1, 8'hA5, 1,  0);
            vecs[4]  = mk(0, 0, 8'h00, 0,   0,  1, 8'hA5, 1,  0);
            vecs[5]  = mk(0, 0, 8'h00, 0,   0,  1, 8'hA5, 1,  0);
            vecs[6]  = mk(0, 0, 8'h00, 1,   0,  1, 8'hA5, 1,  0);
            vecs[7]  = mk(0, 0, 8'h00, 1,   0,  1, 8'hA5, 1,  0);
            vecs[8]  = mk(0, 0, 8'h00, 1,   0,  0, 8'hA5, 1,  0);
            vecs[9]  = mk(0, 0, 8'h00, 1,   0,  0, 8'hA5, 1,  0);
            vecs[10] = mk(0, 0, 8'h00, 1,   0,  0, 8'hA5, 1,  0);
            vecs[11] = mk(0, 0, 8'h00, 0,   0,  0, 8'hA5, 1,  0);
            vecs[12] = mk(0, 0, 8'h00, 0,   0,  0, 8'hA5, 1,  0);
            vecs[13] = mk(0, 0, 8'h00, 0,   1,  0, 8'hA5, 0,  1);
            vecs[14] = mk(0, 0, 8'h00, 0,   1,  0, 8'hA5, 0,  0);
            vecs[15] = mk(0, 0, 8'h00, 1,   1,  0, 8'hA5, 0,  0);
            vecs[16] = mk(0, 0, 8'h00, 1,   0,  0, 8'hA5, 0,  0);
            vecs[17] = mk(0, 1, 8'h77, 1,   0,  0, 8'hA5, 0,  0);
            vecs[18] = mk(0, 1, 8'h77, 1,   0,  0, 8'hA5, 0,  0);
            vecs[19] = mk(0, 1, 8'h77, 0,   0,  0, 8'hA5, 0,  0);
            vecs[20] = mk(0, 0, 8'h00, 0,   1,  0, 8'hA5, 0,  0);

            for (int i = 0; i < 21; i++) begin
                @(negedge clk_ff);
                rst      = vecs[i].rst;
                in_valid = vecs[i].valid;
                in_data  = vecs[i].data;
                tx_ack   = vecs[i].ack;
                @(posedge clk_ff);
                #1;
                check($sformatf("vec%0d {rdy,req,data,busy,done}", i),
                      {in_ready, tx_req, tx_data, busy, done},
                      {vecs[i].e_rdy, vecs[i].e_req, vecs[i].e_data, vecs[i].e_busy, vecs[i].e_done});
            end
        end

        begin : back_pressure
            logic [DATA_W-1:0] words[3];
            int idx = 0, dcnt = 0, launches = 0;
            logic fire, req_prev;
            words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
            req_prev = 1'b0;
            for (int cyc = 0; cyc < 200 && dcnt < 3; cyc++) begin
                @(negedge clk_ff);
                respond();
                in_valid = (idx < 3);
                in_data  = (idx < 3) ? words[idx] : '0;
                #1;
                fire = in_valid && in_ready;
                @(posedge clk_ff);
                #1;
                if (fire) idx++;
                if (tx_req && !req_prev) launches++;
                req_prev = tx_req;
                if (busy || done) check($sformatf("bp_hold word%0d", dcnt), tx_data, words[dcnt]);
                if (done) dcnt++;
            end
            @(negedge clk_ff);
            in_valid = 1'b0;
            check("bp_done_count", dcnt, 3);
            check("bp_req_launches", launches, 3);
            check("bp_words_accepted", idx, 3);
        end

        begin : reset_mid_req
            @(negedge clk_ff);
            in_valid = 1'b1;
            in_data  = 8'h5C;
            @(posedge clk_ff);
            #1;
            check("rst_seq launch {req,data}", {tx_req, tx_data}, {1'b1, 8'h5C});
            @(negedge clk_ff);
            in_valid = 1'b0;
            tx_ack   = 1'b1;
            @(negedge clk_ff);
            check("rst_seq req before reset", tx_req, 1'b1);
            rst = 1'b1;
            @(posedge clk_ff);
            #1;
            check("rst_seq at reset {rdy,req,data,busy,done}",
                  {in_ready, tx_req, tx_data, busy, done}, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
            @(negedge clk_ff);
            rst = 1'b0;
            for (int k = 0; k < 9; k++) begin
                if (k == 5) begin
                    @(negedge clk_ff);
                    tx_ack = 1'b0;
                end
                @(posedge clk_ff);
                #1;
                check($sformatf("rst_seq cyc%0d {rdy,req,busy,done}", k),
                      {in_ready, tx_req, busy, done}, {~ack_m[SYNC_STAGES-1], 1'b0, 1'b0, 1'b0});
            end
            check("rst_seq ready after ack drains", in_ready, 1'b1);
        end
`else
        begin : buffered
            bit got_done;
            repeat (2) @(posedge clk_ff);
            #1;
            check("buf reset {req,data,busy,done}", {tx_req, tx_data, busy, done}, {1'b0, 8'h00, 1'b0, 1'b0});
            @(negedge clk_ff);
            rst = 1'b0;
            #1;
            check("buf ready after reset", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = 8'h01;
            @(posedge clk_ff);
            #1;
            check("buf first launch {rdy,req,data}", {in_ready, tx_req, tx_data}, {1'b1, 1'b1, 8'h01});
            @(negedge clk_ff);
            in_data = 8'h02;
            @(posedge clk_ff);
            #1;
            check("buf second buffered {rdy,req,data}", {in_ready, tx_req, tx_data}, {1'b0, 1'b1, 8'h01});
            @(negedge clk_ff);
            in_valid = 1'b0;
            got_done = 1'b0;
            for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
                @(negedge clk_ff);
                respond();
                @(posedge clk_ff);
                #1;
                check("buf hold 0x01 {rdy,data}", {in_ready, tx_data}, {1'b0, 8'h01});
                got_done = done;
            end
            check("buf first done seen", got_done, 1'b1);
            @(negedge clk_ff);
            respond();
            @(posedge clk_ff);
            #1;
            check("buf second launch {rdy,req,data,busy}",
                  {in_ready, tx_req, tx_data, busy}, {1'b1, 1'b1, 8'h02, 1'b1});
            got_done = 1'b0;
            for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
                @(negedge clk_ff);
                respond();
                @(posedge clk_ff);
                #1;
                check("buf hold 0x02", tx_data, 8'h02);
                got_done = done;
            end
            check("buf second done seen", got_done, 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
